ai_vector_mac_engine: RTL and testbench

//  Parametrised multi-cycle signed vector multiply-accumulate engine for the EX-stage AI datapath.

---
 rtl/ai_vector_mac_engine.sv | 144 ++++++++++++++
 tb/tb_ai_vector_mac_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ai_vector_mac_engine.sv
// Signed LANES-wide vector MAC over len beats with raw/ReLU/step post-op; optional clamp via AI_MAC_SAT_EN.
// Latency: done pulses in the cycle after edge E(L+1), where E0 samples start (len==0: after E1).
// Backpressure: in_ready is high only in RUN; bubbles stall RUN without losing state; start ignored unless IDLE.
module ai_vector_mac_engine #(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MAX_LEN = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic [1:0]                mode,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ELEM_W-1:0]   vec_a,
    input  logic [LANES*ELEM_W-1:0]   vec_b,
    output logic                      busy,
    output logic                      done,
    output logic [ACC_W-1:0]          result,
    output logic                      sat_flag
);
    localparam int PW = 2 * ELEM_W + $clog2(LANES);
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt;
    logic [1:0]              mode_q;
    logic                    p_v;
    logic signed [PW-1:0]    p_sum;
    logic signed [ACC_W-1:0] acc;

    logic signed [PW-1:0]    dot;
    logic signed [SW-1:0]    sum_w;
    logic signed [ACC_W-1:0] acc_red;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] post;
    logic                    ovf;
    logic                    ovf_hit;

    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);

    always_comb begin
        logic signed [ELEM_W-1:0] ea;
        logic signed [ELEM_W-1:0] eb;
        dot = '0;
        for (int i = 0; i < LANES; i++) begin
            ea  = vec_a[i*ELEM_W +: ELEM_W];
            eb  = vec_b[i*ELEM_W +: ELEM_W];
            dot = dot + PW'(ea) * PW'(eb);
        end
    end

    // Add at full width so the overflow test only has to inspect the bits above ACC_W-1.
    always_comb begin
        sum_w = SW'(acc) + SW'(p_sum);
`ifdef AI_MAC_SAT_EN
        ovf = (sum_w[SW-1:ACC_W-1] != {(SW-ACC_W+1){sum_w[SW-1]}});
        if (!ovf)
            acc_red = sum_w[ACC_W-1:0];
        else if (sum_w[SW-1])
            acc_red = {1'b1, {(ACC_W-1){1'b0}}};
        else
            acc_red = {1'b0, {(ACC_W-1){1'b1}}};
`else
        ovf     = 1'b0;
        acc_red = sum_w[ACC_W-1:0];
`endif
        acc_next = p_v ? acc_red : acc;
        ovf_hit  = p_v & ovf;
    end

    always_comb begin
        case (mode_q)
            2'b01:   post = (acc_next < 0) ? '0 : acc_next;
            2'b10:   post = (acc_next > 0) ? ACC_W'(1) : '0;
            default: post = acc_next;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt      <= '0;
            mode_q   <= '0;
            p_v      <= 1'b0;
            p_sum    <= '0;
            acc      <= '0;
            done     <= 1'b0;
            result   <= '0;
            sat_flag <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            p_v   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            p_v  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        sat_flag <= 1'b0;
                        len_q    <= (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
                        mode_q   <= mode;
                        state    <= (len == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (ovf_hit)
                        sat_flag <= 1'b1;
                    if (in_valid) begin
                        p_sum <= dot;
                        p_v   <= 1'b1;
                        cnt   <= cnt + LEN_W'(1);
                        if (cnt == len_q - LEN_W'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    acc    <= acc_next;
                    if (ovf_hit)
                        sat_flag <= 1'b1;
                    result <= post;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ai_vector_mac_engine.sv
// Directed bench for ai_vector_mac_engine at ACC_W=16; expectations for the wide-sum case follow AI_MAC_SAT_EN.
module tb_ai_vector_mac_engine;
    localparam int LW = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [1:0]  mode = '0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] vec_a = '0;
    logic [31:0] vec_b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        sat_flag;

    int n_chk = 0;
    int n_fail = 0;
    int done_total = 0;

    ai_vector_mac_engine #(.LANES(4), .ELEM_W(8), .ACC_W(16), .MAX_LEN(16)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .vec_a(vec_a), .vec_b(vec_b),
        .busy(busy), .done(done), .result(result), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_total++;

    // Runs one operation and reports what was observed; the calling test does the comparing.
    task automatic do_op(input int n, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input bit bubble, input bit hold,
                         output logic [15:0] res, output int dcnt, output int done_cyc, output int end_cyc,
                         output int beats, output bit rdy_drop, output bit tmo);
        bit v;
        res = '0; dcnt = 0; done_cyc = -1; end_cyc = -1; beats = 0; rdy_drop = 0; tmo = 1; v = 1;
        @(negedge clk);
        start = 1; len = LW'(n); mode = m; vec_a = a; vec_b = b; in_valid = 0;
        @(negedge clk);
        start = hold;
        for (int c = 0; c < 200; c++) begin
            in_valid = (beats < n) && v;
            if (beats < n && in_ready !== 1'b1) rdy_drop = 1;
            if (in_valid && in_ready === 1'b1) beats++;
            @(negedge clk);
            if (done === 1'b1) begin dcnt++; res = result; done_cyc = c; end
            if (busy === 1'b0) begin end_cyc = c; tmo = 0; break; end
            if (bubble) v = !v;
        end
        in_valid = 0; start = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if ({busy, done, in_ready, sat_flag} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, done, in_ready, sat_flag}); end
        n_chk++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] r; int dc, dcy, ecy, bt; bit rd, to;
        do_op(1, 2'b00, 32'h04030201, 32'h08070605, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (to || r !== 16'd70) begin n_fail++; $display("FAIL basic_result: got %0d to=%0b want 70", $signed(r), to); end
        n_chk++; if (dcy != 1 || ecy != 2) begin n_fail++; $display("FAIL basic_latency: done_cyc %0d end_cyc %0d want 1 2", dcy, ecy); end
        n_chk++; if (dc != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", dc); end
        do_op(4, 2'b11, 32'h0201FF80, 32'h03027F02, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        // lanes: 2*3 + 1*2 + (-1)*127 + (-128)*2 = -375 per beat, x4 = -1500
        n_chk++; if (to || r !== 16'(-1500)) begin n_fail++; $display("FAIL mode3_raw: got %0d want -1500", $signed(r)); end
        n_chk++; if (dcy != 4) begin n_fail++; $display("FAIL len4_latency: done_cyc %0d want 4", dcy); end
    endtask

    task automatic test_bubbles_postop();
        logic [15:0] r; int dc, dcy, ecy, bt; bit rd, to;
        logic [15:0] want [3] = '{16'(-24), 16'd0, 16'd0};
        for (int k = 0; k < 3; k++) begin
            do_op(3, 2'(k), 32'hFFFFFFFF, 32'h02020202, 1, 0, r, dc, dcy, ecy, bt, rd, to);
            n_chk++; if (to || r !== want[k]) begin n_fail++;
                $display("FAIL bubble_mode%0d: got %0d want %0d", k, $signed(r), $signed(want[k])); end
            n_chk++; if (rd || bt != 3) begin n_fail++; $display("FAIL bubble_ready%0d: drop=%0b beats=%0d want 0 3", k, rd, bt); end
        end
        do_op(1, 2'b10, 32'h00000001, 32'h00000001, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (r !== 16'd1) begin n_fail++; $display("FAIL step_pos: got %0d want 1", $signed(r)); end
        do_op(2, 2'b01, 32'h00000003, 32'h00000005, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (r !== 16'd30) begin n_fail++; $display("FAIL relu_pos: got %0d want 30", $signed(r)); end
    endtask

    task automatic test_saturation();
        logic [15:0] r; int dc, dcy, ecy, bt; bit rd, to;
        logic [15:0] want_r; logic want_s;
`ifdef AI_MAC_SAT_EN
        want_r = 16'd32767; want_s = 1'b1;
`else
        want_r = 16'(-16320); want_s = 1'b0;
`endif
        do_op(16, 2'b00, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (to || r !== want_r) begin n_fail++; $display("FAIL sat_result: got %0d want %0d", $signed(r), $signed(want_r)); end
        n_chk++; if (sat_flag !== want_s) begin n_fail++; $display("FAIL sat_flag: got %b want %b", sat_flag, want_s); end
        do_op(1, 2'b00, 32'h00000001, 32'h00000002, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (sat_flag !== 1'b0 || r !== 16'd2) begin n_fail++;
            $display("FAIL sat_cleared: flag %b result %0d want 0 2", sat_flag, $signed(r)); end
    endtask

    task automatic test_len0_and_ignored_start();
        logic [15:0] r; int dc, dcy, ecy, bt, d0; bit rd, to;
        d0 = done_total;
        do_op(0, 2'b10, 32'h01010101, 32'h01010101, 0, 1, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (to || r !== 16'd0 || dcy != 0) begin n_fail++; $display("FAIL len0: result %0d done_cyc %0d want 0 0", $signed(r), dcy); end
        n_chk++; if (dc != 1 || done_total - d0 != 1) begin n_fail++; $display("FAIL len0_one_done: got %0d/%0d want 1", dc, done_total - d0); end
        d0 = done_total;
        do_op(2, 2'b00, 32'h01010101, 32'h01010101, 0, 1, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (to || r !== 16'd8 || dcy != 2) begin n_fail++; $display("FAIL start_held: result %0d done_cyc %0d want 8 2", $signed(r), dcy); end
        repeat (3) @(negedge clk);
        n_chk++; if (done_total - d0 != 1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL start_held_once: dones %0d busy %b want 1 0", done_total - d0, busy); end
    endtask

    task automatic test_clear();
        logic [15:0] r; int dc, dcy, ecy, bt, d0; bit rd, to;
        d0 = done_total;
        @(negedge clk); start = 1; len = LW'(4); mode = 2'b00; vec_a = 32'h01010101; vec_b = 32'h01010101;
        @(negedge clk); start = 0; in_valid = 1;
        @(negedge clk); clear = 1; start = 1;
        @(negedge clk); clear = 0; in_valid = 0; start = 0;
        n_chk++; if ({busy, in_ready, done} !== 3'b000) begin n_fail++; $display("FAIL clear_idle: got %b want 000", {busy, in_ready, done}); end
        n_chk++; if (result !== 16'd8) begin n_fail++; $display("FAIL clear_result_hold: got %0d want 8", $signed(result)); end
        repeat (4) @(negedge clk);
        n_chk++; if (done_total != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_no_done: dones %0d busy %b want 0 0", done_total - d0, busy); end
        do_op(2, 2'b00, 32'h01010101, 32'h03030303, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (to || r !== 16'd24) begin n_fail++; $display("FAIL clear_rerun: got %0d want 24", $signed(r)); end
    endtask

    task automatic test_async_reset();
        logic [15:0] r; int dc, dcy, ecy, bt, d0; bit rd, to;
        @(negedge clk); start = 1; len = LW'(3); mode = 2'b00; vec_a = 32'h01010101; vec_b = 32'h03030303;
        @(negedge clk); start = 0; in_valid = 1;
        @(negedge clk);
        d0 = done_total;
        #2 reset = 1'b0;
        #1;
        n_chk++; if ({busy, in_ready, done, sat_flag} !== 4'b0000 || result !== 16'h0) begin n_fail++;
            $display("FAIL async_reset: ctrl %b result %0d want 0000 0", {busy, in_ready, done, sat_flag}, $signed(result)); end
        in_valid = 0;
        @(negedge clk); reset = 1'b1;
        n_chk++; if (done_total != d0) begin n_fail++; $display("FAIL async_reset_no_done: dones %0d want 0", done_total - d0); end
        do_op(2, 2'b00, 32'h04030201, 32'h02020202, 0, 0, r, dc, dcy, ecy, bt, rd, to);
        n_chk++; if (to || r !== 16'd40) begin n_fail++; $display("FAIL reset_rerun: got %0d want 40", $signed(r)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles_postop();
        test_saturation();
        test_len0_and_ignored_start();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
